// File: rtl/token_pkg.sv
// Shared defaults and types for the token-chain stages (double_tokens, halve_tokens family).
package token_pkg;

  localparam int TOKEN_FACTOR_DEF = 2;
  localparam int TOKEN_CNT_W_DEF  = 4;

  typedef logic [TOKEN_CNT_W_DEF-1:0] token_cnt_t;

endpackage

// File: rtl/token_sat_counter.sv
// Up/down counter that adds inc_i, subtracts dec_i and clips at 2**CNT_W-1.
module token_sat_counter
  import token_pkg::*;
#(
  parameter int CNT_W = TOKEN_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             clip_o
);

  localparam logic [CNT_W:0] MAX_C = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   sum_s;
  logic             dec_s;

  // Extra headroom bit exposes the excess so only the overshoot is discarded.
  always_comb begin
    dec_s = dec_i & (count_q != {CNT_W{1'b0}});
    sum_s = {1'b0, count_q} - {{CNT_W{1'b0}}, dec_s} + {1'b0, inc_i};
    if (sum_s > MAX_C) begin
      count_d = MAX_C[CNT_W-1:0];
      clip_o  = 1'b1;
    end else begin
      count_d = sum_s[CNT_W-1:0];
      clip_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/double_tokens.sv
// Serial token expander: each input token becomes FACTOR output tokens.
// Optional zero-latency bypass when DOUBLE_TOKENS_BYPASS_EN is defined.
module double_tokens
  import token_pkg::*;
#(
  parameter int FACTOR = TOKEN_FACTOR_DEF,
  parameter int CNT_W  = TOKEN_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             b,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FACTOR_C = FACTOR[CNT_W-1:0];
`ifdef DOUBLE_TOKENS_BYPASS_EN
  localparam int               FACTOR_M1 = FACTOR - 1;
  localparam logic [CNT_W-1:0] FACTOR_M1_C = FACTOR_M1[CNT_W-1:0];
`endif

  logic [CNT_W-1:0] pending_s;
  logic [CNT_W-1:0] inc_s;
  logic             clip_s;
  logic             a_s;
  logic             nonzero_s;
  logic             overflow_q;

  assign a_s       = a & ~rst;
  assign nonzero_s = (pending_s != {CNT_W{1'b0}});

  // Token arrival contribution; with bypass an idle counter forwards one token at once.
  always_comb begin
    inc_s = {CNT_W{1'b0}};
    if (a_s) begin
`ifdef DOUBLE_TOKENS_BYPASS_EN
      if (!nonzero_s) begin
        inc_s = FACTOR_M1_C;
      end else begin
        inc_s = FACTOR_C;
      end
`else
      inc_s = FACTOR_C;
`endif
    end else begin
      inc_s = {CNT_W{1'b0}};
    end
  end

  token_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_s),
    .dec_i   (nonzero_s),
    .count_o (pending_s),
    .clip_o  (clip_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (clip_s) begin
      overflow_q <= 1'b1;
    end else begin
      overflow_q <= overflow_q;
    end
  end

`ifdef DOUBLE_TOKENS_BYPASS_EN
  assign b = nonzero_s | a_s;
`else
  assign b = nonzero_s;
`endif
  assign busy     = nonzero_s;
  assign pending  = pending_s;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_double_tokens.sv
// Self-checking bench for double_tokens: directed scenarios plus randomized traffic vs. a token-count model.
module tb_double_tokens;

  localparam int FACTOR = 2;
  localparam int CNT_W  = 4;
  localparam int MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             a;
  logic             b;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  int n_checks;
  int n_errors;
  int m_pend;
  bit m_ovf;
  logic last_b;
  int   last_pend;

  double_tokens #(.FACTOR(FACTOR), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One cycle: drive, compare outputs against the model, then advance the model past the edge.
  task automatic step(input logic a_v, input logic rst_v);
    logic exp_b;
    int   gain;
    @(negedge clk);
    a   = a_v;
    rst = rst_v;
    #1;
    exp_b = (m_pend > 0);
`ifdef DOUBLE_TOKENS_BYPASS_EN
    if (a_v && !rst_v) exp_b = 1'b1;
`endif
    check_val("b", {31'd0, b}, {31'd0, exp_b});
    check_val("pending", {28'd0, pending}, m_pend);
    check_val("busy", {31'd0, busy}, (m_pend > 0) ? 32'd1 : 32'd0);
    check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    last_b    = b;
    last_pend = m_pend;
    @(posedge clk);
    if (rst_v) begin
      m_pend = 0;
      m_ovf  = 1'b0;
    end else begin
      gain = a_v ? FACTOR : 0;
`ifdef DOUBLE_TOKENS_BYPASS_EN
      if (a_v && m_pend == 0) gain = FACTOR - 1;
`endif
      m_pend = m_pend - ((m_pend > 0) ? 1 : 0) + gain;
      if (m_pend > MAX) begin
        m_pend = MAX;
        m_ovf  = 1'b1;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_pend != 0; i++) step(1'b0, 1'b0);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] a_v, input logic [7:0] b_v);
    drain();
    for (int i = 7; i >= 0; i--) begin
      step(a_v[i], 1'b0);
      check_val(tag, {31'd0, last_b}, {31'd0, b_v[i]});
    end
  endtask

  initial begin
    int hi_cnt;
    int pct;
    n_checks = 0;
    n_errors = 0;
    m_pend   = 0;
    m_ovf    = 1'b0;
    rst      = 1'b1;
    a        = 1'b0;
    @(posedge clk);

    // Reset hold with a asserted: nothing may leak through.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Single token: pending 0, FACTOR, ..., 0.
    begin
      logic [7:0] av;
      av = 8'b1000_0000;
      for (int i = 7; i >= 4; i--) begin
        step(av[i], 1'b0);
`ifdef DOUBLE_TOKENS_BYPASS_EN
        check_val("single_pend", last_pend, (i == 7) ? 0 : (i == 6) ? 1 : 0);
`else
        check_val("single_pend", last_pend, (i == 7) ? 0 : (i == 6) ? 2 : (i == 5) ? 1 : 0);
`endif
      end
    end

`ifdef DOUBLE_TOKENS_BYPASS_EN
    run_vec("byp_1000", 8'b1000_0000, 8'b1100_0000);
    run_vec("byp_1010", 8'b1010_0000, 8'b1111_0000);
    run_vec("byp_1101", 8'b1101_0000, 8'b1111_1100);
`else
    run_vec("single", 8'b1000_0000, 8'b0110_0000);
    run_vec("b2b",    8'b1100_0000, 8'b0111_1000);
    run_vec("burst",  8'b1101_0000, 8'b0111_1110);
    run_vec("gap",    8'b1010_0000, 8'b0111_1000);
`endif
    check_val("no_ovf_bursts", {31'd0, overflow}, 32'd0);

    // Saturation: a held high for 20 cycles.
    drain();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0);
`ifdef DOUBLE_TOKENS_BYPASS_EN
      if (k == 15) begin
        check_val("sat_pend15", last_pend, 15);
        check_val("sat_ovf_lo", {31'd0, overflow}, 32'd0);
      end
      if (k == 16) check_val("sat_ovf_hi", {31'd0, overflow}, 32'd1);
`else
      if (k == 14) begin
        check_val("sat_pend15", last_pend, 15);
        check_val("sat_ovf_lo", {31'd0, overflow}, 32'd0);
      end
      if (k == 15) check_val("sat_ovf_hi", {31'd0, overflow}, 32'd1);
`endif
    end
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0);
      if (last_b) hi_cnt++;
    end
    check_val("drain_len", hi_cnt, 15);
    check_val("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-burst from pending=9.
    step(1'b0, 1'b1);
    while (m_pend < 9) step(1'b1, 1'b0);
    check_val("pre_rst_pend", m_pend, 9);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_val("post_rst_pend", last_pend, 0);
    check_val("post_rst_b", {31'd0, last_b}, 32'd0);
    check_val("post_rst_ovf", {31'd0, overflow}, 32'd0);
`ifdef DOUBLE_TOKENS_BYPASS_EN
    run_vec("rst_single", 8'b1000_0000, 8'b1100_0000);
`else
    run_vec("rst_single", 8'b1000_0000, 8'b0110_0000);
`endif

    // Randomized traffic with varying density and rare resets.
    for (int seg = 0; seg < 12; seg++) begin
      pct = (seg % 3 == 0) ? 15 : (seg % 3 == 1) ? 50 : 85;
      for (int i = 0; i < 40; i++) begin
        step(($urandom_range(99) < pct) ? 1'b1 : 1'b0,
             ($urandom_range(59) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
